gmii_tx_framer: RTL and testbench

GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

---
 rtl/gmii_pkg.sv | 27 ++
 rtl/gmii_ce_counter.sv | 30 +++
 rtl/gmii_tx_framer.sv | 176 +++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII transmit framer: state encoding,
// preamble/SFD byte constants and the saturating byte-counter helper.
package gmii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAD      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_IFG      = 3'd6
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [7:0] IDLE_BYTE     = 8'h00;

  localparam int BYTE_CNT_W = 11;
  localparam logic [BYTE_CNT_W-1:0] BYTE_CNT_MAX = '1;

  // Frame byte counter increment that sticks at its maximum value.
  function automatic logic [BYTE_CNT_W-1:0] byte_cnt_inc(input logic [BYTE_CNT_W-1:0] cnt);
    return (cnt == BYTE_CNT_MAX) ? cnt : cnt + BYTE_CNT_W'(1);
  endfunction

endpackage

// File: rtl/gmii_ce_counter.sv
// Byte-time down-counter shared by the preamble and inter-frame-gap phases.
// A load is taken on any clock; counting only happens on enabled byte-times
// and stops at zero, so the zero flag marks the final byte-time of a phase.
module gmii_ce_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load has priority; otherwise step down once per enabled byte-time.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (ce && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps an upstream byte stream (FCS already appended)
// with preamble and SFD, pads short frames, flags underruns with tx_er,
// drains the remainder of an aborted frame and enforces the inter-frame gap.
// All GMII outputs change only on byte-times selected by tx_ce.
module gmii_tx_framer
  import gmii_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
  parameter int PAD_EN       = 1,
  parameter int MIN_LEN      = 60
) (
  input  logic        tx_clk_125,
  input  logic        rst,
  input  logic        tx_ce,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_d,
  output logic        tx_en,
  output logic        tx_er,
  output logic [15:0] frame_cnt,
  output logic [7:0]  underrun_cnt,
  output logic        busy
);

  // IDLE already emits the first preamble byte, so PREAMBLE covers the rest;
  // the counter is loaded with "remaining bytes minus one" so zero means last.
  localparam int PRE_LOAD_INT = (PREAMBLE_LEN >= 2) ? PREAMBLE_LEN - 2 : 0;
  localparam logic [7:0] PRE_LOAD = 8'(PRE_LOAD_INT);
  localparam logic [7:0] IFG_LOAD = 8'(IFG_LEN - 1);

  tx_state_t               state;
  logic [BYTE_CNT_W-1:0]   byte_cnt;
  logic [BYTE_CNT_W-1:0]   byte_next;
  logic                    pad_needed;
  logic                    pad_done;
  logic                    go_preamble;
  logic                    go_ifg;
  logic                    cnt_load;
  logic [7:0]              cnt_load_value;
  logic                    cnt_ce;
  logic                    cnt_zero;

  // Phase-transition decisions shared by the state machine and the counter.
  always_comb begin
    byte_next      = byte_cnt_inc(byte_cnt);
    pad_needed     = (PAD_EN != 0) && (int'(byte_next) < MIN_LEN);
    pad_done       = (int'(byte_next) >= MIN_LEN);
    go_preamble    = (state == ST_IDLE) && tx_ce && s_valid;
    go_ifg         = ((state == ST_DATA) && tx_ce && s_valid && s_last && !pad_needed) ||
                     ((state == ST_PAD) && tx_ce && pad_done) ||
                     ((state == ST_DRAIN) && s_valid && s_last);
    cnt_load       = go_preamble || go_ifg;
    cnt_load_value = go_ifg ? IFG_LOAD : PRE_LOAD;
    cnt_ce         = tx_ce && ((state == ST_PREAMBLE) || (state == ST_IFG));
  end

  gmii_ce_counter #(
    .W(8)
  ) u_phase_cnt (
    .clk       (tx_clk_125),
    .rst       (rst),
    .ce        (cnt_ce),
    .load      (cnt_load),
    .load_value(cnt_load_value),
    .zero      (cnt_zero)
  );

  assign s_ready = ((state == ST_DATA) && tx_ce) || (state == ST_DRAIN);
  assign busy    = (state != ST_IDLE);

  // Framing state machine with registered GMII outputs and statistics.
  always_ff @(posedge tx_clk_125) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx_d         <= IDLE_BYTE;
      tx_en        <= 1'b0;
      tx_er        <= 1'b0;
      byte_cnt     <= '0;
      frame_cnt    <= '0;
      underrun_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (tx_ce) begin
            if (s_valid) begin
              tx_d  <= PREAMBLE_BYTE;
              tx_en <= 1'b1;
              tx_er <= 1'b0;
              state <= (PREAMBLE_LEN > 1) ? ST_PREAMBLE : ST_SFD;
            end else begin
              tx_d  <= IDLE_BYTE;
              tx_en <= 1'b0;
              tx_er <= 1'b0;
            end
          end
        end
        ST_PREAMBLE: begin
          if (tx_ce) begin
            tx_d  <= PREAMBLE_BYTE;
            tx_en <= 1'b1;
            tx_er <= 1'b0;
            if (cnt_zero) state <= ST_SFD;
          end
        end
        ST_SFD: begin
          if (tx_ce) begin
            tx_d     <= SFD_BYTE;
            tx_en    <= 1'b1;
            tx_er    <= 1'b0;
            byte_cnt <= '0;
            state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tx_ce) begin
            if (s_valid) begin
              tx_d     <= s_data;
              tx_en    <= 1'b1;
              tx_er    <= 1'b0;
              byte_cnt <= byte_next;
              if (s_last) begin
                if (pad_needed) begin
                  state <= ST_PAD;
                end else begin
                  state     <= ST_IFG;
                  frame_cnt <= frame_cnt + 16'd1;
                end
              end
            end else begin
              tx_d  <= IDLE_BYTE;
              tx_en <= 1'b1;
              tx_er <= 1'b1;
              if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
              state <= ST_DRAIN;
            end
          end
        end
        ST_PAD: begin
          if (tx_ce) begin
            tx_d     <= IDLE_BYTE;
            tx_en    <= 1'b1;
            tx_er    <= 1'b0;
            byte_cnt <= byte_next;
            if (pad_done) begin
              state     <= ST_IFG;
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          if (tx_ce) begin
            tx_d  <= IDLE_BYTE;
            tx_en <= 1'b0;
            tx_er <= 1'b0;
          end
          if (s_valid && s_last) state <= ST_IFG;
        end
        ST_IFG: begin
          if (tx_ce) begin
            tx_d  <= IDLE_BYTE;
            tx_en <= 1'b0;
            tx_er <= 1'b0;
            if (cnt_zero) state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer with default parameters: full frame,
// padding at a slow byte rate, underrun/drain, reset mid-frame,
// back-to-back gap and underrun counter saturation.
module tb_gmii_tx_framer;

  localparam int CLK_HALF = 5;

  logic        tx_clk_125 = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ce = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_d;
  logic        tx_en;
  logic        tx_er;
  logic [15:0] frame_cnt;
  logic [7:0]  underrun_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int ce_period = 1;
  int ce_phase = 0;

  bit         cap_on = 1'b0;
  logic [9:0] samp_q[$];
  logic [7:0] obs_bytes[$];
  logic [7:0] exp_bytes[$];
  int         obs_found, obs_start, obs_end, obs_en_len, obs_er_cnt, obs_hold_err, obs_gap;
  logic       obs_last_er;

  gmii_tx_framer dut (
    .tx_clk_125  (tx_clk_125),
    .rst         (rst),
    .tx_ce       (tx_ce),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .tx_d        (tx_d),
    .tx_en       (tx_en),
    .tx_er       (tx_er),
    .frame_cnt   (frame_cnt),
    .underrun_cnt(underrun_cnt),
    .busy        (busy)
  );

  // Free-running clock.
  initial forever #CLK_HALF tx_clk_125 = ~tx_clk_125;

  // Byte-time enable: one cycle in every ce_period, changed on falling edges.
  initial forever begin
    @(negedge tx_clk_125);
    tx_ce    = (ce_phase == 0);
    ce_phase = (ce_phase + 1 >= ce_period) ? 0 : ce_phase + 1;
  end

  // Record {tx_er, tx_en, tx_d} once per clock, just after the rising edge.
  initial forever begin
    @(posedge tx_clk_125);
    #1;
    if (cap_on) samp_q.push_back({tx_er, tx_en, tx_d});
  end

  task automatic set_ce(input int p);
    ce_period = p;
    ce_phase  = 0;
  endtask

  task automatic do_reset();
    @(negedge tx_clk_125);
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    repeat (2) @(negedge tx_clk_125);
    rst = 1'b0;
  endtask

  task automatic release_source();
    @(negedge tx_clk_125);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic start_capture();
    samp_q.delete();
    cap_on = 1'b1;
  endtask

  // Expected GMII byte stream: 7 preamble, SFD, incrementing data, zero pad.
  task automatic build_expected(input int n_data, input int base, input int n_pad);
    exp_bytes.delete();
    repeat (7) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int k = 0; k < n_data; k++) exp_bytes.push_back(8'(base + k));
    repeat (n_pad) exp_bytes.push_back(8'h00);
  endtask

  // Decode one tx_en burst starting at or after sample index 'from'.
  task automatic decode_run(input int from, input int period);
    int j;
    int s;
    obs_bytes.delete();
    obs_found = 0; obs_start = -1; obs_end = from; obs_en_len = 0;
    obs_er_cnt = 0; obs_hold_err = 0; obs_gap = 0; obs_last_er = 1'b0;
    s = -1;
    for (int k = from; k < samp_q.size(); k++) begin
      if (samp_q[k][8]) begin s = k; break; end
    end
    if (s < 0) return;
    obs_found = 1; obs_start = s; j = s;
    while (j < samp_q.size() && samp_q[j][8]) begin
      if ((j - s) % period == 0) begin
        obs_bytes.push_back(samp_q[j][7:0]);
        if (samp_q[j][9]) obs_er_cnt++;
      end else if (samp_q[j] !== samp_q[j-1]) begin
        obs_hold_err++;
      end
      obs_en_len++;
      j++;
    end
    obs_end = j;
    obs_last_er = samp_q[j-1][9];
    while (j < samp_q.size() && !samp_q[j][8]) begin
      obs_gap++;
      j++;
    end
  endtask

  function automatic int first_diff();
    for (int k = 0; k < exp_bytes.size(); k++)
      if (k >= obs_bytes.size() || obs_bytes[k] !== exp_bytes[k]) return k;
    if (obs_bytes.size() != exp_bytes.size()) return exp_bytes.size();
    return -1;
  endfunction

  function automatic logic [7:0] obs_at(input int k);
    return (k >= 0 && k < obs_bytes.size()) ? obs_bytes[k] : 8'hxx;
  endfunction

  function automatic logic [7:0] exp_at(input int k);
    return (k >= 0 && k < exp_bytes.size()) ? exp_bytes[k] : 8'hxx;
  endfunction

  // Present bytes base+i; optionally stall after 'stall_after' bytes, or
  // return early after 'stop_after' bytes. drain_cycles counts clocks used
  // to deliver the bytes that follow the stall.
  task automatic drive_frame(input int len, input int base, input int stall_after,
                             input int stop_after, output int drain_cycles);
    int i, cycles, stall_left;
    bit stalled, acc;
    i = 0; cycles = 0; stall_left = 0; stalled = 0; drain_cycles = 0;
    while (i < len && cycles < 20000) begin
      @(negedge tx_clk_125);
      cycles++;
      if (stalled && stall_left == 0) drain_cycles++;
      if (stall_left > 0) begin
        s_valid = 1'b0; s_last = 1'b0;
        stall_left--;
        acc = 1'b0;
      end else begin
        s_valid = 1'b1; s_data = 8'(base + i); s_last = (i == len - 1);
        #1;
        acc = s_ready;
      end
      @(posedge tx_clk_125);
      if (acc) begin
        i++;
        if (i == stall_after) begin stall_left = 2 * ce_period + 1; stalled = 1; end
        if (i == stop_after) break;
      end
    end
    checks++;
    if (i != len && i != stop_after) begin
      failures++;
      $display("[TB] FAIL drive_bound: accepted %0d bytes, required %0d", i, len);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge tx_clk_125);
      n++;
    end while (busy && n < limit);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL idle_bound: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    set_ce(1);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0;
    repeat (3) @(negedge tx_clk_125);
    checks++; if (tx_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_en: got %b required 0", tx_en); end
    checks++; if (tx_er !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_er: got %b required 0", tx_er); end
    checks++; if (tx_d !== 8'h00) begin failures++; $display("[TB] FAIL reset_tx_d: got %h required 00", tx_d); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready: got %b required 0", s_ready); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("[TB] FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
    checks++; if (underrun_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_underrun_cnt: got %0d required 0", underrun_cnt); end
    s_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int d, diff;
    do_reset();
    set_ce(1);
    start_capture();
    drive_frame(64, 0, -1, -1, d);
    release_source();
    wait_idle(500);
    repeat (4) @(negedge tx_clk_125);
    cap_on = 1'b0;
    decode_run(0, 1);
    build_expected(64, 0, 0);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL full_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (obs_en_len != 72) begin failures++; $display("[TB] FAIL full_en_len: got %0d required 72", obs_en_len); end
    checks++; if (obs_er_cnt != 0) begin failures++; $display("[TB] FAIL full_tx_er: got %0d er bytes required 0", obs_er_cnt); end
    checks++; if (obs_gap < 12) begin failures++; $display("[TB] FAIL full_idle_after: got %0d idle cycles required >=12", obs_gap); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("[TB] FAIL full_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_pad_slow_ce();
    int d, diff;
    do_reset();
    set_ce(10);
    start_capture();
    drive_frame(10, 8'hA0, -1, -1, d);
    release_source();
    wait_idle(3000);
    cap_on = 1'b0;
    decode_run(0, 10);
    build_expected(10, 8'hA0, 50);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL pad_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (obs_en_len != 680) begin failures++; $display("[TB] FAIL pad_en_len: got %0d required 680", obs_en_len); end
    checks++; if (obs_hold_err != 0) begin failures++; $display("[TB] FAIL pad_hold: got %0d changes between byte-times required 0", obs_hold_err); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("[TB] FAIL pad_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_underrun();
    int drained, diff;
    do_reset();
    set_ce(4);
    start_capture();
    drive_frame(100, 0, 21, -1, drained);
    release_source();
    wait_idle(1000);
    cap_on = 1'b0;
    decode_run(0, 4);
    build_expected(21, 0, 1);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL underrun_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (obs_en_len != 120) begin failures++; $display("[TB] FAIL underrun_en_len: got %0d required 120", obs_en_len); end
    checks++; if (obs_er_cnt != 1 || obs_last_er !== 1'b1) begin failures++; $display("[TB] FAIL underrun_tx_er: got %0d er bytes last_er=%b required 1 on final byte", obs_er_cnt, obs_last_er); end
    checks++; if (drained != 79) begin failures++; $display("[TB] FAIL underrun_drain: got %0d clocks for 79 bytes required 79", drained); end
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("[TB] FAIL underrun_cnt: got %0d required 1", underrun_cnt); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("[TB] FAIL underrun_frame_cnt: got %0d required 0", frame_cnt); end
    decode_run(obs_end, 4);
    checks++; if (obs_found != 0) begin failures++; $display("[TB] FAIL underrun_quiet: got tx_en burst at sample %0d required none", obs_start); end
  endtask

  // Runs right after test_underrun so both counters are nonzero before reset.
  task automatic test_reset_mid_frame();
    int d, diff;
    set_ce(1);
    drive_frame(8, 8'h40, -1, -1, d);
    release_source();
    wait_idle(500);
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("[TB] FAIL pre_rst_frame_cnt: got %0d required 1", frame_cnt); end
    checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("[TB] FAIL pre_rst_underrun_cnt: got %0d required 1", underrun_cnt); end
    drive_frame(100, 0, -1, 5, d);
    @(negedge tx_clk_125);
    checks++; if (tx_en !== 1'b1 || tx_d !== 8'h04) begin failures++; $display("[TB] FAIL pre_rst_data: got en=%b d=%h required en=1 d=04", tx_en, tx_d); end
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0;
    @(posedge tx_clk_125);
    #1;
    checks++; if (tx_en !== 1'b0 || tx_er !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_outputs: got en=%b er=%b required en=0 er=0", tx_en, tx_er); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: got %b required 0", busy); end
    checks++; if (frame_cnt !== 16'd0 || underrun_cnt !== 8'd0) begin failures++; $display("[TB] FAIL rst_mid_counters: got frame=%0d underrun=%0d required 0/0", frame_cnt, underrun_cnt); end
    @(negedge tx_clk_125);
    rst = 1'b0;
    start_capture();
    drive_frame(64, 8'h10, -1, -1, d);
    release_source();
    wait_idle(500);
    cap_on = 1'b0;
    decode_run(0, 1);
    build_expected(64, 8'h10, 0);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL post_rst_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (obs_en_len != 72 || obs_er_cnt != 0) begin failures++; $display("[TB] FAIL post_rst_shape: got len=%0d er=%0d required 72/0", obs_en_len, obs_er_cnt); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("[TB] FAIL post_rst_frame_cnt: got %0d required 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int d, diff, gap_ab;
    do_reset();
    set_ce(1);
    start_capture();
    drive_frame(20, 8'h20, -1, -1, d);
    drive_frame(1, 8'hEE, -1, -1, d);
    release_source();
    wait_idle(500);
    cap_on = 1'b0;
    decode_run(0, 1);
    gap_ab = obs_gap;
    build_expected(20, 8'h20, 40);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL b2b_a_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (gap_ab != 12) begin failures++; $display("[TB] FAIL b2b_gap: got %0d idle byte-times required 12", gap_ab); end
    decode_run(obs_end, 1);
    build_expected(1, 8'hEE, 59);
    diff = first_diff();
    checks++; if (diff != -1) begin failures++; $display("[TB] FAIL b2b_b_bytes: index %0d got %h required %h", diff, obs_at(diff), exp_at(diff)); end
    checks++; if (frame_cnt !== 16'd2) begin failures++; $display("[TB] FAIL b2b_frame_cnt: got %0d required 2", frame_cnt); end
  endtask

  task automatic test_underrun_saturation();
    int d;
    do_reset();
    set_ce(1);
    for (int k = 1; k <= 256; k++) begin
      drive_frame(2, k, 1, -1, d);
      if (k == 1) begin
        checks++; if (underrun_cnt !== 8'd1) begin failures++; $display("[TB] FAIL sat_first: got %0d required 1", underrun_cnt); end
      end
      if (k == 255) begin
        checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("[TB] FAIL sat_255: got %0d required 255", underrun_cnt); end
      end
    end
    release_source();
    wait_idle(500);
    checks++; if (underrun_cnt !== 8'd255) begin failures++; $display("[TB] FAIL sat_256: got %0d required 255", underrun_cnt); end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("[TB] FAIL sat_frame_cnt: got %0d required 0", frame_cnt); end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_full_frame();
    test_pad_slow_ce();
    test_underrun();
    test_reset_mid_frame();
    test_back_to_back();
    test_underrun_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
